// File: rtl/q2a03_bus_pkg.sv
// Shared types and address map for the Q2A03 CPU bus responder.
package q2a03_bus_pkg;

  typedef enum logic [1:0] {
    RAM  = 2'd0,
    IO   = 2'd1,
    OPEN = 2'd2,
    PRG  = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  localparam logic [15:0] RAM_LAST    = 16'h1FFF;
  localparam logic [15:0] IO_LAST     = 16'h401F;
  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam logic [15:0] PRG_BASE    = 16'h8000;

  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr <= RAM_LAST)     return RAM;
    else if (addr <= IO_LAST) return IO;
    else if (addr < PRG_BASE) return OPEN;
    else                      return PRG;
  endfunction

endpackage

// File: rtl/q2a03_oam_dma.sv
// OAM DMA engine: ALIGN, then 256 READ/WRITE pairs, each DMA_CYC clocks long.
module q2a03_oam_dma
  import q2a03_bus_pkg::*;
#(
  parameter int DMA_CYC = 12
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        start,
  input  logic [7:0]  page,
  input  logic [7:0]  fetch_data,
  output logic        busy,
  output logic        launch,
  output logic [15:0] dma_addr,
  output logic        G_ready,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we
);

  localparam int CNT_W = (DMA_CYC > 1) ? $clog2(DMA_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DMA_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_STRB  = CNT_W'(DMA_CYC - 2);
  // The fetch lands two clocks after launch, matching the CPU rise+2 timing.
  localparam logic [CNT_W-1:0] CNT_FETCH = CNT_W'(2);

  dma_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       page_q;
  logic             cyc_end;

  assign cyc_end  = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);
  assign launch   = (state == READ) && (cnt == '0);
  assign dma_addr = {page_q, oam_addr};

  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; blocking assignments would create order-dependent logic.
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      page_q   <= 8'h00;
      G_ready  <= 1'b1;
      oam_addr <= 8'h00;
      oam_data <= 8'h00;
      oam_we   <= 1'b0;
    end else begin
      oam_we <= 1'b0;
      if (state == IDLE) cnt <= '0;
      else               cnt <= cyc_end ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            page_q  <= page;
            state   <= ALIGN;
            G_ready <= 1'b0;
          end
        end
        ALIGN: begin
          if (cyc_end) state <= READ;
        end
        READ: begin
          if (cnt == CNT_FETCH) oam_data <= fetch_data;
          if (cyc_end) state <= WRITE;
        end
        WRITE: begin
          // Strobe sits in the last clock so oam_addr is still the target index.
          if (cnt == CNT_STRB) oam_we <= 1'b1;
          if (cyc_end) begin
            oam_addr <= oam_addr + 8'd1;
            if (oam_addr == 8'hFF) begin
              state   <= IDLE;
              G_ready <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/q2a03_bus_responder.sv
// Q2A03 CPU bus slave: decode, internal RAM, I/O/PRG forwarding, open bus.
// Optional OAM DMA engine is built when Q2A03_OAM_DMA_EN is defined.
module q2a03_bus_responder
  import q2a03_bus_pkg::*;
#(
  parameter int RAM_AW  = 11,
  parameter int DMA_CYC = 12
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic [15:0] G_addr,
  input  logic [7:0]  G_wr_data,
  input  logic        G_rdwr,
  input  logic        G_phy2,
  output logic [7:0]  G_rd_data,
  output logic        G_ready,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_data,
  output logic [15:0] io_addr,
  output logic [7:0]  io_wr_data,
  output logic        io_we,
  output logic        io_re,
  input  logic [7:0]  io_rd_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we
);

  logic        phy2_q;
  logic        rise, fall;
  logic        dma_busy, dma_launch;
  logic [15:0] dma_addr;
  logic        is_dma_reg;
  logic [15:0] eff_addr;
  region_t     eff_rgn, cpu_rgn, rd_rgn;
  logic        cpu_launch, launch, cpu_write;
  logic [1:0]  cpu_pipe;
  logic [7:0]  ram_q, bus_latch, src_data;
  logic [7:0]  mem [2**RAM_AW];

  assign rise = G_phy2 & ~phy2_q;
  assign fall = ~G_phy2 & phy2_q;

  // DMA borrows the address path while the CPU is frozen.
  assign eff_addr   = dma_busy ? dma_addr : G_addr;
  assign eff_rgn    = decode_region(eff_addr);
  assign cpu_rgn    = decode_region(G_addr);
  assign prg_addr   = eff_addr[14:0];
  assign io_addr    = eff_addr;
  assign io_wr_data = G_wr_data;

  assign cpu_launch = rise & G_rdwr & ~dma_busy;
  assign launch     = cpu_launch | dma_launch;
  assign cpu_write  = fall & ~G_rdwr & ~dma_busy;

`ifdef Q2A03_OAM_DMA_EN
  logic dma_start;

  assign is_dma_reg = (G_addr == OAMDMA_ADDR);
  assign dma_start  = cpu_write & is_dma_reg;

  q2a03_oam_dma #(
    .DMA_CYC (DMA_CYC)
  ) u_oam_dma (
    .G_clock    (G_clock),
    .G_reset    (G_reset),
    .start      (dma_start),
    .page       (G_wr_data),
    .fetch_data (src_data),
    .busy       (dma_busy),
    .launch     (dma_launch),
    .dma_addr   (dma_addr),
    .G_ready    (G_ready),
    .oam_addr   (oam_addr),
    .oam_data   (oam_data),
    .oam_we     (oam_we)
  );
`else
  assign is_dma_reg = 1'b0;
  assign dma_busy   = 1'b0;
  assign dma_launch = 1'b0;
  assign dma_addr   = 16'h0000;
  assign G_ready    = 1'b1;
  assign oam_addr   = 8'h00;
  assign oam_data   = 8'h00;
  assign oam_we     = 1'b0;
`endif

  // NOTE: the RAM array and its read register carry no reset; contents are
  // undefined at power-up on the real part, and a reset would forbid a RAM macro.
  always_ff @(posedge G_clock) begin
    if (cpu_write && cpu_rgn == RAM) mem[G_addr[RAM_AW-1:0]] <= G_wr_data;
    if (launch) ram_q <= mem[eff_addr[RAM_AW-1:0]];
  end

  // NOTE: src_data gets a default before the case so no path can infer a latch.
  always_comb begin
    src_data = bus_latch;
    case (rd_rgn)
      RAM:     src_data = ram_q;
      IO:      src_data = io_rd_data;
      PRG:     src_data = prg_data;
      default: src_data = bus_latch;
    endcase
  end

  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      phy2_q    <= 1'b1;
      rd_rgn    <= RAM;
      cpu_pipe  <= 2'b00;
      G_rd_data <= 8'h00;
      io_re     <= 1'b0;
      io_we     <= 1'b0;
      bus_latch <= 8'h00;
    end else begin
      phy2_q   <= G_phy2;
      io_re    <= launch && (eff_rgn == IO);
      cpu_pipe <= {cpu_pipe[0], cpu_launch};
      if (launch)      rd_rgn    <= eff_rgn;
      if (cpu_pipe[1]) G_rd_data <= src_data;
      io_we <= cpu_write && (cpu_rgn == IO) && !is_dma_reg;
      // Open bus remembers whatever byte last crossed the bus at fall.
      if (fall && !dma_busy) bus_latch <= G_rdwr ? G_rd_data : G_wr_data;
    end
  end

endmodule

// File: tb/tb_q2a03_bus_responder.sv
// Directed self-checking bench for q2a03_bus_responder (both DMA builds).
module tb_q2a03_bus_responder;

  logic        G_clock = 1'b0;
  logic        G_reset = 1'b0;
  logic [15:0] G_addr = 16'h0000;
  logic [7:0]  G_wr_data = 8'h00;
  logic        G_rdwr = 1'b1;
  logic        G_phy2 = 1'b0;
  logic [7:0]  G_rd_data;
  logic        G_ready;
  logic [14:0] prg_addr;
  logic [7:0]  prg_data;
  logic [15:0] io_addr;
  logic [7:0]  io_wr_data;
  logic        io_we, io_re;
  logic [7:0]  io_rd_data = 8'h00;
  logic [7:0]  oam_addr, oam_data;
  logic        oam_we;

  int total = 0;
  int bad = 0;
  int io_we_cnt = 0, io_re_cnt = 0, oam_cnt = 0, ready_low_total = 0;
  logic [15:0] last_io_addr = 16'h0000;
  logic [7:0]  last_io_wdata = 8'h00;
  logic [7:0]  rec_addr [1024];
  logic [7:0]  rec_data [1024];

  q2a03_bus_responder dut (
    .G_clock    (G_clock),
    .G_reset    (G_reset),
    .G_addr     (G_addr),
    .G_wr_data  (G_wr_data),
    .G_rdwr     (G_rdwr),
    .G_phy2     (G_phy2),
    .G_rd_data  (G_rd_data),
    .G_ready    (G_ready),
    .prg_addr   (prg_addr),
    .prg_data   (prg_data),
    .io_addr    (io_addr),
    .io_wr_data (io_wr_data),
    .io_we      (io_we),
    .io_re      (io_re),
    .io_rd_data (io_rd_data),
    .oam_addr   (oam_addr),
    .oam_data   (oam_data),
    .oam_we     (oam_we)
  );

  always #5 G_clock = ~G_clock;

  // Simple PRG ROM and I/O device models.
  assign prg_data = (prg_addr == 15'h0123) ? 8'hA9 : prg_addr[7:0];
  always @(posedge G_clock) if (io_re) io_rd_data <= io_addr[7:0] ^ 8'hC3;

  always @(negedge G_clock) begin
    if (io_we) begin
      io_we_cnt++;
      last_io_addr  = io_addr;
      last_io_wdata = io_wr_data;
    end
    if (io_re) io_re_cnt++;
    if (oam_we) begin
      if (oam_cnt < 1024) begin
        rec_addr[oam_cnt] = oam_addr;
        rec_data[oam_cnt] = oam_data;
      end
      oam_cnt++;
    end
    if (!G_ready) ready_low_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One 12-clock CPU bus cycle starting with the phy2 rise; called at a negedge.
  task automatic cpu_cycle(input logic [15:0] addr, input logic rdwr, input logic [7:0] wdata,
                           output logic [7:0] rd_early, output logic [7:0] rd_data);
    G_addr = addr;
    G_rdwr = rdwr;
    G_wr_data = wdata;
    G_phy2 = 1'b1;
    @(negedge G_clock);
    @(negedge G_clock);
    rd_early = G_rd_data;
    @(negedge G_clock);
    rd_data = G_rd_data;
    repeat (3) @(negedge G_clock);
    G_phy2 = 1'b0;
    repeat (6) @(negedge G_clock);
  endtask

`ifdef Q2A03_OAM_DMA_EN
  // Write the page to $4014 and count clocks with G_ready low (bounded).
  task automatic dma_kick(input logic [7:0] page, output int low_clks);
    G_addr = 16'h4014;
    G_rdwr = 1'b0;
    G_wr_data = page;
    G_phy2 = 1'b1;
    repeat (6) @(negedge G_clock);
    G_phy2 = 1'b0;
    low_clks = 0;
    for (int k = 0; k < 8000; k++) begin
      @(negedge G_clock);
      if (!G_ready) low_clks++;
      else if (low_clks > 0) break;
    end
    G_rdwr = 1'b1;
    G_addr = 16'h0000;
    repeat (2) @(negedge G_clock);
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e, d;
    int snap, low, base;
    logic hit;

    repeat (3) @(negedge G_clock);
    check("rst_rd_data", G_rd_data, 8'h00);
    check("rst_ready", G_ready, 1'b1);
    check("rst_strobes", {io_we, io_re, oam_we}, 3'b000);
    check("rst_oam", {oam_addr, oam_data}, 16'h0000);
    G_reset = 1'b1;
    repeat (2) @(negedge G_clock);

    // RAM mirroring and rise+2 latency
    cpu_cycle(16'h0805, 1'b0, 8'h5A, e, d);
    cpu_cycle(16'h1005, 1'b1, 8'h00, e, d);
    check("mirror_early", e, 8'h00);
    check("mirror_read", d, 8'h5A);

    // PRG read; previous data holds until rise+2
    cpu_cycle(16'h8123, 1'b1, 8'h00, e, d);
    check("prg_addr", prg_addr, 15'h0123);
    check("prg_hold", e, 8'h5A);
    check("prg_read", d, 8'hA9);

    // Open bus returns last byte seen at fall, no io_re
    cpu_cycle(16'h0000, 1'b0, 8'h33, e, d);
    snap = io_re_cnt;
    cpu_cycle(16'h5000, 1'b1, 8'h00, e, d);
    check("open_read", d, 8'h33);
    check("open_no_io_re", io_re_cnt - snap, 0);

    // I/O write: one strobe at fall
    snap = io_we_cnt;
    cpu_cycle(16'h2001, 1'b0, 8'h1E, e, d);
    check("io_we_count", io_we_cnt - snap, 1);
    check("io_we_addr", last_io_addr, 16'h2001);
    check("io_we_data", last_io_wdata, 8'h1E);

    // Region boundaries
    cpu_cycle(16'h07FF, 1'b0, 8'hAB, e, d);
    cpu_cycle(16'h1FFF, 1'b1, 8'h00, e, d);
    check("ram_last", d, 8'hAB);
    snap = io_re_cnt;
    cpu_cycle(16'h401F, 1'b1, 8'h00, e, d);
    check("io_last_read", d, 8'hDC);
    check("io_last_re", io_re_cnt - snap, 1);
    snap = io_re_cnt;
    cpu_cycle(16'h4020, 1'b1, 8'h00, e, d);
    check("open_first", d, 8'hDC);
    check("open_first_re", io_re_cnt - snap, 0);

    // PRG and open-bus writes are dropped
    snap = io_we_cnt;
    cpu_cycle(16'h8005, 1'b0, 8'h77, e, d);
    cpu_cycle(16'h6000, 1'b0, 8'h66, e, d);
    check("drop_no_io_we", io_we_cnt - snap, 0);
    cpu_cycle(16'h0005, 1'b1, 8'h00, e, d);
    check("drop_prg_wr", d, 8'h5A);
    cpu_cycle(16'h0000, 1'b1, 8'h00, e, d);
    check("drop_open_wr", d, 8'h33);

`ifdef Q2A03_OAM_DMA_EN
    for (int i = 0; i < 256; i++) cpu_cycle(16'h0200 + 16'(i), 1'b0, 8'(i) ^ 8'hFF, e, d);

    snap = io_we_cnt;
    base = oam_cnt;
    dma_kick(8'h02, low);
    check("dma_stall", low, 6156);
    check("dma_no_io_we", io_we_cnt - snap, 0);
    check("dma_count", oam_cnt - base, 256);
    for (int i = 0; i < 256; i++)
      check($sformatf("dma_byte%0d", i), {rec_addr[base+i], rec_data[base+i]},
            {8'(i), 8'(i) ^ 8'hFF});
    check("dma_end_addr", oam_addr, 8'h00);
    check("dma_end_ready", G_ready, 1'b1);

    // Reset during byte 100 aborts at once
    G_addr = 16'h4014;
    G_rdwr = 1'b0;
    G_wr_data = 8'h02;
    G_phy2 = 1'b1;
    repeat (6) @(negedge G_clock);
    G_phy2 = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 8000 && !hit; k++) begin
      @(negedge G_clock);
      if (oam_we && oam_addr == 8'd100) hit = 1'b1;
    end
    check("abort_reached", hit, 1'b1);
    #1;
    G_reset = 1'b0;
    G_rdwr = 1'b1;
    G_addr = 16'h0000;
    #1;
    check("abort_ready", G_ready, 1'b1);
    check("abort_oam_we", oam_we, 1'b0);
    check("abort_oam_addr", oam_addr, 8'h00);
    repeat (2) @(negedge G_clock);
    G_reset = 1'b1;
    repeat (2) @(negedge G_clock);

    base = oam_cnt;
    dma_kick(8'h02, low);
    check("restart_stall", low, 6156);
    check("restart_count", oam_cnt - base, 256);
    check("restart_first", {rec_addr[base], rec_data[base]}, 16'h00FF);
    check("restart_last", {rec_addr[base+255], rec_data[base+255]}, 16'hFF00);
`else
    snap = io_we_cnt;
    cpu_cycle(16'h4014, 1'b0, 8'h05, e, d);
    check("4014_io_we", io_we_cnt - snap, 1);
    check("4014_io_addr", last_io_addr, 16'h4014);
    check("4014_ready", ready_low_total, 0);
    check("4014_oam", {oam_we, oam_addr, oam_data}, 17'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
